// File: rtl/cpu_run_ctrl_if.sv
// rtl/cpu_run_ctrl_if.sv - core-side monitor bus between an RV32I core and its run controller
interface cpu_run_ctrl_if #(
    parameter int XLEN = 32
);
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            instr_retire;
    logic [XLEN-1:0] pc;
    logic            cpu_reset;

    modport master (
        output dmem_we, dmem_addr, dmem_wdata, instr_retire, pc,
        input  cpu_reset
    );

    modport slave (
        input  dmem_we, dmem_addr, dmem_wdata, instr_retire, pc,
        output cpu_reset
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - core reset sequencer with cycle/retire counters and tohost/timeout/hang stop
module cpu_run_ctrl #(
    parameter int              XLEN         = 32,
    parameter int              CNT_W        = 32,
    parameter int              RESET_CYCLES = 4,
    parameter int              MAX_CYCLES   = 1000,
    parameter int              HANG_CYCLES  = 64,
    parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h0000_0FFC
) (
    input  logic              clk,
    input  logic              reset,
    cpu_run_ctrl_if.slave     core,
    output logic              running,
    output logic              done,
    output logic [2:0]        status,
    output logic [XLEN-2:0]   fail_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  retire_count
);
    localparam int RST_W = $clog2(RESET_CYCLES + 1);

    // Encoding matches the status output so status is the state register itself.
    typedef enum logic [2:0] {
        ST_RST     = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_HUNG    = 3'd5
    } state_t;

    state_t            state, state_nx;
    logic [RST_W-1:0]  rst_cnt, rst_cnt_nx;
    logic [CNT_W-1:0]  cyc_nx, ret_nx, hang_cnt, hang_nx;
    logic [XLEN-1:0]   last_pc, last_pc_nx;
    logic [XLEN-2:0]   fail_nx;
    logic              cpu_reset_q;
    logic              tohost;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign status         = state;
    assign core.cpu_reset = cpu_reset_q;
    assign tohost         = core.dmem_we && (core.dmem_addr == TOHOST_ADDR);

    always_comb begin
        state_nx   = state;
        rst_cnt_nx = rst_cnt;
        cyc_nx     = cycle_count;
        ret_nx     = retire_count;
        hang_nx    = hang_cnt;
        last_pc_nx = last_pc;
        fail_nx    = fail_code;
        case (state)
            ST_RST: begin
                rst_cnt_nx = rst_cnt + RST_W'(1);
                if (rst_cnt == RST_W'(RESET_CYCLES - 1))
                    state_nx = ST_RUN;
            end
            ST_RUN: begin
                cyc_nx     = sat_inc(cycle_count);
                ret_nx     = core.instr_retire ? sat_inc(retire_count) : retire_count;
                hang_nx    = (core.pc == last_pc) ? sat_inc(hang_cnt) : '0;
                last_pc_nx = core.pc;
                // Terminating cycle still commits its counter updates; tohost wins ties.
                if (tohost && core.dmem_wdata == XLEN'(1)) begin
                    state_nx = ST_PASS;
                end else if (tohost && core.dmem_wdata != '0) begin
                    state_nx = ST_FAIL;
                    fail_nx  = core.dmem_wdata[XLEN-1:1];
                end else if (MAX_CYCLES != 0 && cyc_nx == CNT_W'(MAX_CYCLES)) begin
                    state_nx = ST_TIMEOUT;
                end else if (HANG_CYCLES != 0 && hang_nx == CNT_W'(HANG_CYCLES)) begin
                    state_nx = ST_HUNG;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_RST;
            rst_cnt      <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
            hang_cnt     <= '0;
            last_pc      <= '0;
            fail_code    <= '0;
            cpu_reset_q  <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            rst_cnt      <= rst_cnt_nx;
            cycle_count  <= cyc_nx;
            retire_count <= ret_nx;
            hang_cnt     <= hang_nx;
            last_pc      <= last_pc_nx;
            fail_code    <= fail_nx;
            cpu_reset_q  <= (state_nx != ST_RUN);
            running      <= (state_nx == ST_RUN);
            done         <= (state_nx != ST_RST) && (state_nx != ST_RUN);
        end
    end
endmodule
